// File: rtl/am2940_seq.sv
// Purpose : sequences one am2940 DMA address slice: program (WCR/LDA/LDW) or
//           reload (INIT), then step once per acknowledged memory word.
// Latency : start -> first RUN cycle is 4 cycles (program) or 2 cycles (reload);
//           FIN follows the RUN cycle that sees done_in with mack, or abort.
// Backpress: mack stalls RUN with mreq held high; start is ignored while busy.
//
// Ports:
//   cp, rst                  clock, synchronous active-high reset
//   start/reload/ctl/addr/cnt host request and programming values
//   abort                    host termination of a running transfer
//   busy/xfer_done/aborted   host status; xcount = acked words this run
//   remaining                2940 word counter, sampled while IDLE
//   i, d_out, d_oe, d_in     2940 instruction and D bus
//   oea_, aci_, wci_         2940 enables (active low)
//   done_in                  2940 DONE, already reflecting the current step
//   mreq, mack               memory handshake
module am2940_seq #(
  parameter int W = 8
) (
  input  logic         cp,
  input  logic         rst,
  input  logic         start,
  input  logic         reload,
  input  logic [2:0]   ctl,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] cnt,
  input  logic         abort,
  output logic         busy,
  output logic         xfer_done,
  output logic         aborted,
  output logic [W:0]   xcount,
  output logic [W-1:0] remaining,
  output logic [2:0]   i,
  output logic [W-1:0] d_out,
  output logic         d_oe,
  input  logic [W-1:0] d_in,
  output logic         oea_,
  output logic         aci_,
  output logic         wci_,
  input  logic         done_in,
  output logic         mreq,
  input  logic         mack
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_WCR  = 3'd1,
    S_LDA  = 3'd2,
    S_LDW  = 3'd3,
    S_INIT = 3'd4,
    RUN    = 3'd5,
    FIN    = 3'd6
  } state_t;

  // 2940 instruction encodings
  localparam logic [2:0] I_WCR  = 3'b000;
  localparam logic [2:0] I_RWC  = 3'b010;
  localparam logic [2:0] I_INIT = 3'b100;
  localparam logic [2:0] I_LDA  = 3'b101;
  localparam logic [2:0] I_LDW  = 3'b110;
  localparam logic [2:0] I_ENA  = 3'b111;

  localparam logic [W:0] XCOUNT_MAX = '1;

  state_t       state, state_nxt;
  logic [2:0]   ctl_q;
  logic [W-1:0] addr_q;
  logic [W-1:0] cnt_q;

  // Next state and 2940-side decode. In RUN the count enables follow mack
  // directly so the 2940 advances on the same edge that completes the word.
  always_comb begin
    state_nxt = state;
    i         = I_RWC;
    d_out     = '0;
    d_oe      = 1'b0;
    oea_      = 1'b1;
    aci_      = 1'b1;
    wci_      = 1'b1;
    mreq      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = reload ? S_INIT : S_WCR;
      end
      S_WCR: begin
        i         = I_WCR;
        d_out     = W'(ctl_q);
        d_oe      = 1'b1;
        state_nxt = S_LDA;
      end
      S_LDA: begin
        i         = I_LDA;
        d_out     = addr_q;
        d_oe      = 1'b1;
        state_nxt = S_LDW;
      end
      S_LDW: begin
        i         = I_LDW;
        d_out     = cnt_q;
        d_oe      = 1'b1;
        state_nxt = RUN;
      end
      S_INIT: begin
        i         = I_INIT;
        state_nxt = RUN;
      end
      RUN: begin
        i    = I_ENA;
        oea_ = 1'b0;
        mreq = 1'b1;
        aci_ = ~mack;
        wci_ = ~mack;
        if (abort || (mack && done_in)) state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign xfer_done = (state == FIN);

  always_ff @(posedge cp) begin
    if (rst) begin
      state     <= IDLE;
      xcount    <= '0;
      aborted   <= 1'b0;
      remaining <= '0;
      ctl_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // i = RWC in IDLE, so d_in carries the 2940 word counter.
          remaining <= d_in;
          if (start) begin
            xcount  <= '0;
            aborted <= 1'b0;
            if (!reload) begin
              ctl_q  <= ctl;
              addr_q <= addr;
              cnt_q  <= cnt;
            end
          end
        end
        RUN: begin
          if (mack && (xcount != XCOUNT_MAX)) xcount <= xcount + 1'b1;
          // An abort coinciding with the final word still counts as a
          // normal completion.
          if (abort)
            aborted <= mack ? ~done_in : 1'b1;
          else if (mack && done_in)
            aborted <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
